pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle fetch/execute controller that owns the 8-bit program counter of the RISC-V core. It issues instruction-memory requests, latches fetched instructions for the datapath, and waits for the datapath to finish each instruction. It then selects the next PC (sequential or jump target) and handles halt and memory-timeout conditions. It sits between the instruction memory and the decode/execute datapath, replacing ad-hoc PC increment logic with one explicit state machine.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- RESET_PC, 0, PC value loaded on reset
- MEM_TIMEOUT, 15, max FETCH cycles without imem_ack before FAULT (legal range 1..255)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  level; permits fetching of new instructions
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address, always equals pc
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr  out  32  latched instruction
- instr_valid  out  1  one-cycle pulse: instr newly latched
- exec_done  in  1  datapath finished current instruction
- jump_valid  in  1  qualified by exec_done: take jump_target
- jump_target  in  PC_W  next PC when jumping
- halt_req  in  1  qualified by exec_done: stop after this instruction
- pc  out  PC_W  current PC
- state  out  3  encoded state: IDLE=0, FETCH=1, EXEC=2, HALTED=3, FAULT=4
- retired  out  16  count of completed instructions, saturating
- fault  out  1  high while in FAULT

## Operation
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0, fault=0, timeout counter=0. rst mid-operation aborts any fetch/exec immediately. The next cycle shows reset values.
- IDLE: imem_req=0. If run=1, go to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ack=1: instr<=imem_rdata, go to EXEC, clear timeout counter.
  - Otherwise, timeout counter increments. When MEM_TIMEOUT consecutive FETCH cycles pass without ack, go to FAULT.
  - An ack on the MEM_TIMEOUT-th cycle wins over the timeout.
  - run is ignored once in FETCH; the fetch always completes or faults.
- EXEC: instr_valid=1 in the first EXEC cycle only. imem_req=0. Wait for exec_done.
  - exec_done=1 with halt_req=1: pc<=pc+1, go to HALTED. jump_valid is ignored.
  - exec_done=1 with jump_valid=1: pc<=jump_target.
  - exec_done=1 otherwise: pc<=pc+1, modulo 2^PC_W (0xFF wraps to 0x00).
  - After exec_done, if not halting: go to FETCH if run=1, else IDLE.
  - exec_done is accepted in the first EXEC cycle, the same cycle as instr_valid.
  - jump_valid and halt_req are ignored when exec_done=0.
- retired: increments by 1 on every accepted exec_done, including the halting one. It holds at 0xFFFF.
- HALTED: imem_req=0. pc and instr hold. Exit only by rst.
- FAULT: fault=1, imem_req=0. pc holds the faulting address. Exit only by rst.
- exec_done outside EXEC is ignored. imem_ack outside FETCH is ignored.

## Timing
- All outputs are registered, or decoded from registered state only. There are no combinational input-to-output paths.
- Best-case instruction, with single-cycle memory, run=1, and exec_done on the first EXEC cycle, takes 2 cycles:
  - cycle n: FETCH with ack.
  - cycle n+1: EXEC, instr_valid, exec_done.
  - cycle n+2: FETCH at the new pc.
- IDLE to first request: run sampled high in cycle n gives imem_req=1 in cycle n+1.
- pc changes only on the clock edge that leaves EXEC via exec_done. imem_addr is stable for the whole FETCH.

## Test plan
- Reset then sequential run: single-cycle ack, immediate exec_done, run=1 → imem_addr sequence 0,1,2,3 on alternate cycles; retired=4 after 8 cycles in FETCH/EXEC.
- Jump: exec_done+jump_valid with jump_target=0x40 at pc=0x05 → next imem_addr=0x40; retired increments once.
- Wrap and wait states: pc=0xFF, ack delayed 3 cycles → imem_req held 4 cycles at 0xFF, then pc=0x00 after exec_done, no fault.
- Timeout: MEM_TIMEOUT=15, no ack → FAULT entered after the 15th FETCH cycle, fault=1, pc unchanged. Ack on the 15th cycle instead → EXEC, no fault.
- Halt and stop: halt_req+jump_valid with exec_done at pc=0x10 → HALTED, pc=0x11, imem_req stays 0 for 20 cycles. Separately, run=0 during EXEC → IDLE after exec_done, then resumes fetching when run returns to 1.
- Reset mid-operation and saturation: rst in EXEC → next cycle state=IDLE, pc=RESET_PC, instr_valid=0. Force retired near 0xFFFF with 3 more exec_done → holds at 0xFFFF.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/execute bus between the PC sequencer, instruction memory and datapath.
// The master side is the sequencer; the slave side is memory plus datapath.
interface pc_sequencer_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic [31:0]     instr;
   logic            instr_valid;
   logic            exec_done;
   logic            jump_valid;
   logic [PC_W-1:0] jump_target;
   logic            halt_req;

   modport master (
      output imem_req, imem_addr, instr, instr_valid,
      input  imem_ack, imem_rdata, exec_done, jump_valid, jump_target, halt_req
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid,
      output imem_ack, imem_rdata, exec_done, jump_valid, jump_target, halt_req
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute controller owning the program counter: fetches,
// hands each instruction to the datapath, then picks the next PC.
module pc_sequencer #(
   parameter int              PC_W        = 8,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int              MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   pc_sequencer_if.master  bus,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      state,
   output logic [15:0]     retired,
   output logic            fault
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] HALTED = 3'd3;
   localparam logic [2:0] FAULT  = 3'd4;

   // Counter value seen on the last permitted ack-less FETCH cycle.
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   logic [2:0]      state_q;
   logic [PC_W-1:0] pc_q;
   logic [31:0]     instr_q;
   logic            instr_valid_q;
   logic [15:0]     retired_q;
   logic [7:0]      tmo_cnt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] v);
      return v + PC_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         retired_q     <= '0;
         tmo_cnt       <= '0;
      end else begin
         instr_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (run) state_q <= FETCH;
            end
            FETCH: begin
               // An ack always wins, even on the final allowed cycle.
               if (bus.imem_ack) begin
                  instr_q       <= bus.imem_rdata;
                  instr_valid_q <= 1'b1;
                  tmo_cnt       <= '0;
                  state_q       <= EXEC;
               end else if (tmo_cnt == TMO_LAST) begin
                  state_q <= FAULT;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            EXEC: begin
               if (bus.exec_done) begin
                  retired_q <= sat_inc(retired_q);
                  if (bus.halt_req) begin
                     pc_q    <= pc_inc(pc_q);
                     state_q <= HALTED;
                  end else begin
                     pc_q    <= bus.jump_valid ? bus.jump_target : pc_inc(pc_q);
                     state_q <= run ? FETCH : IDLE;
                  end
               end
            end
            default: begin
               // HALTED and FAULT are sticky until reset.
            end
         endcase
      end
   end

   assign bus.imem_req    = (state_q == FETCH);
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign pc              = pc_q;
   assign state           = state_q;
   assign retired         = retired_q;
   assign fault           = (state_q == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetched words go into a scoreboard queue and
// are checked when instr_valid appears; pc/retired follow a small model.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        run;
   logic [7:0]  pc;
   logic [2:0]  state;
   logic [15:0] retired;
   logic        fault;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic [15:0] exp_ret;
   logic [7:0]  exp_pc;
   logic [31:0] e;

   pc_sequencer_if #(.PC_W(8)) bus ();

   pc_sequencer #(
      .PC_W(8),
      .RESET_PC(8'h00),
      .MEM_TIMEOUT(15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .bus(bus),
      .pc(pc),
      .state(state),
      .retired(retired),
      .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
   endfunction

   // Starts in a FETCH cycle at address a; waits nwait cycles, acks with d,
   // then completes the instruction with the given jump/halt/run controls.
   task automatic fetch_exec(input logic [7:0] a, input int nwait, input logic [31:0] d,
                             input logic jv, input logic [7:0] jt, input logic hr,
                             input logic r);
      for (int i = 0; i < nwait; i++) begin
         chk("req_wait", bus.imem_req, 1);
         chk("addr_wait", bus.imem_addr, a);
         bus.imem_ack = 1'b0;
         tick();
      end
      chk("state_fetch", state, 1);
      chk("req", bus.imem_req, 1);
      chk("addr", bus.imem_addr, a);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = d;
      exp_q.push_back(d);
      tick();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      chk("state_exec", state, 2);
      chk("instr_valid", bus.instr_valid, 1);
      chk("req_exec", bus.imem_req, 0);
      chk("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("instr", bus.instr, e);
      end
      bus.exec_done   = 1'b1;
      bus.jump_valid  = jv;
      bus.jump_target = jt;
      bus.halt_req    = hr;
      run             = r;
      exp_ret         = sat16(exp_ret);
      exp_pc          = (jv && !hr) ? jt : a + 8'd1;
      tick();
      bus.exec_done  = 1'b0;
      bus.jump_valid = 1'b0;
      bus.halt_req   = 1'b0;
      chk("pc", pc, exp_pc);
      chk("retired", retired, exp_ret);
      chk("instr_valid_clr", bus.instr_valid, 0);
      chk("state_next", state, hr ? 3 : (r ? 1 : 0));
   endtask

   initial begin
      rst             = 1'b1;
      run             = 1'b0;
      bus.imem_ack    = 1'b0;
      bus.imem_rdata  = '0;
      bus.exec_done   = 1'b0;
      bus.jump_valid  = 1'b0;
      bus.jump_target = '0;
      bus.halt_req    = 1'b0;
      exp_ret         = '0;
      exp_pc          = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_ivld", bus.instr_valid, 0);
      chk("rst_req", bus.imem_req, 0);
      chk("rst_retired", retired, 0);
      chk("rst_fault", fault, 0);

      // Sequential run: request appears one cycle after run goes high.
      run = 1'b1;
      tick();
      chk("idle_to_fetch", bus.imem_req, 1);
      for (int i = 0; i < 4; i++)
         fetch_exec(8'(i), 0, 32'hA000_0000 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b1);
      chk("retired4", retired, 4);

      // Jump from 0x05 to 0x40.
      fetch_exec(8'h04, 0, 32'h1111_0004, 1'b0, 8'h00, 1'b0, 1'b1);
      fetch_exec(8'h05, 0, 32'h1111_0005, 1'b1, 8'h40, 1'b0, 1'b1);
      chk("jump_addr", bus.imem_addr, 8'h40);

      // Wrap from 0xFF with three wait states.
      fetch_exec(8'h40, 0, 32'h2222_0040, 1'b1, 8'hFF, 1'b0, 1'b1);
      fetch_exec(8'hFF, 3, 32'h3333_00FF, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("wrap_fault", fault, 0);

      // Ack on the final allowed cycle beats the timeout.
      fetch_exec(8'h00, 14, 32'h4444_0000, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("late_ack_fault", fault, 0);

      // run low during EXEC parks in IDLE; stray exec_done is ignored there.
      fetch_exec(8'h01, 0, 32'h5555_0001, 1'b0, 8'h00, 1'b0, 1'b0);
      bus.exec_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_hold", state, 0);
         chk("idle_req", bus.imem_req, 0);
         chk("idle_retired", retired, exp_ret);
      end
      bus.exec_done = 1'b0;
      run = 1'b1;
      tick();
      chk("resume_state", state, 1);
      chk("resume_addr", bus.imem_addr, 8'h02);

      // Halt wins over jump; HALTED ignores run, ack and exec_done.
      fetch_exec(8'h02, 0, 32'h6666_0002, 1'b1, 8'h10, 1'b0, 1'b1);
      fetch_exec(8'h10, 0, 32'h7777_0010, 1'b1, 8'h33, 1'b1, 1'b1);
      bus.imem_ack  = 1'b1;
      bus.exec_done = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halt_req", bus.imem_req, 0);
         chk("halt_state", state, 3);
         chk("halt_pc", pc, 8'h11);
         chk("halt_retired", retired, exp_ret);
         chk("halt_instr", bus.instr, 32'h7777_0010);
      end
      bus.imem_ack  = 1'b0;
      bus.exec_done = 1'b0;

      // Timeout into FAULT after 15 ack-less FETCH cycles.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_ret = '0;
      chk("rst2_state", state, 0);
      chk("rst2_pc", pc, 0);
      tick();
      for (int i = 0; i < 15; i++) begin
         chk("tmo_fetch", state, 1);
         chk("tmo_fault_low", fault, 0);
         tick();
      end
      chk("tmo_state", state, 4);
      chk("tmo_fault", fault, 1);
      chk("tmo_pc", pc, 0);
      chk("tmo_req", bus.imem_req, 0);
      bus.imem_ack = 1'b1;
      tick();
      tick();
      bus.imem_ack = 1'b0;
      chk("tmo_sticky", state, 4);

      // Reset while in EXEC.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      fetch_exec(8'h00, 0, 32'h8888_0000, 1'b0, 8'h00, 1'b0, 1'b1);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h9999_0001;
      tick();
      bus.imem_ack = 1'b0;
      chk("pre_rst_exec", state, 2);
      rst           = 1'b1;
      bus.exec_done = 1'b1;
      tick();
      rst           = 1'b0;
      bus.exec_done = 1'b0;
      exp_ret       = '0;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_pc", pc, 0);
      chk("mid_rst_ivld", bus.instr_valid, 0);
      chk("mid_rst_instr", bus.instr, 0);
      chk("mid_rst_retired", retired, 0);

      // Saturation of the retired counter.
      tick();
      force dut.retired_q = 16'hFFFD;
      #1;
      release dut.retired_q;
      exp_ret = 16'hFFFD;
      for (int i = 0; i < 3; i++)
         fetch_exec(8'(i), 0, 32'hB000_0000 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b1);
      chk("sat_hold", retired, 16'hFFFF);
      chk("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
